// File: rtl/fdiv_rr_sched.sv
// fdiv_rr_sched: round-robin front end that shares one pipelined FP32
// Newton-Raphson divider (fixed latency, no enable) between two requesters.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   req{0,1}_valid/a/b  operand pair offered by each requester
//   req{0,1}_ready      pair accepted this cycle (combinational grant)
//   div_a, div_b        registered operands driven to the divider
//   div_c               quotient returned by the divider
//   res{0,1}_valid      one-cycle pulse: res_data belongs to that requester
//   res_data            registered quotient
//   inflight, busy      ops issued and not yet returned; inflight != 0
module fdiv_rr_sched #(
  parameter int DIV_LAT = 12,  // edges from A/B change to quotient on C
  parameter int CW      = 7    // inflight width, 2**CW > DIV_LAT+1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [31:0]   req0_a,
  input  logic [31:0]   req0_b,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [31:0]   req1_a,
  input  logic [31:0]   req1_b,
  output logic          req1_ready,
  output logic [31:0]   div_a,
  output logic [31:0]   div_b,
  input  logic [31:0]   div_c,
  output logic          res0_valid,
  output logic          res1_valid,
  output logic [31:0]   res_data,
  output logic [CW-1:0] inflight,
  output logic          busy
);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } opnd_t;

  // Tag pipe: one valid bit and one requester id per in-flight stage.
  // Stage DIV_LAT lines up with the edge on which div_c holds the quotient.
  logic [DIV_LAT:0] vld_pipe;
  logic [DIV_LAT:0] id_pipe;
  logic             last;     // requester granted most recently
  logic             issue;
  logic             ret;
  opnd_t            gnt_op;

  // Contention goes to whichever requester did not win last time.
  always_comb begin
    req0_ready = req0_valid & (~req1_valid | last);
    req1_ready = req1_valid & (~req0_valid | ~last);
    issue      = req0_ready | req1_ready;
    gnt_op     = req1_ready ? '{a: req1_a, b: req1_b} : '{a: req0_a, b: req0_b};
  end

  assign ret  = vld_pipe[DIV_LAT];
  assign busy = |inflight;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe   <= '0;
      id_pipe    <= '0;
      last       <= 1'b1;
      div_a      <= '0;
      div_b      <= '0;
      res0_valid <= 1'b0;
      res1_valid <= 1'b0;
      res_data   <= '0;
      inflight   <= '0;
    end else begin
      // Shifts every edge; the divider cannot stall so neither can the tags.
      vld_pipe <= {vld_pipe[DIV_LAT-1:0], issue};
      id_pipe  <= {id_pipe[DIV_LAT-1:0], req1_ready};

      // Operands hold between issues so the divider input stays quiet.
      if (issue) begin
        div_a <= gnt_op.a;
        div_b <= gnt_op.b;
        last  <= req1_ready;
      end

      res0_valid <= ret & ~id_pipe[DIV_LAT];
      res1_valid <= ret &  id_pipe[DIV_LAT];
      if (ret) res_data <= div_c;

      case ({issue, ret})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_rr_sched.sv
// Bench for fdiv_rr_sched: a fixed-latency divider stub feeds div_c, and an
// edge-indexed schedule of expected returns serves as the reference model.
module tb_fdiv_rr_sched;
  localparam int LAT = 12;
  localparam int CW  = 7;
  localparam int NE  = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic          req0_ready, req1_ready;
  logic [31:0]   div_a, div_b, div_c;
  logic          res0_valid, res1_valid;
  logic [31:0]   res_data;
  logic [CW-1:0] inflight;
  logic          busy;

  always #5 clk = ~clk;

  fdiv_rr_sched #(.DIV_LAT(LAT), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .div_a(div_a), .div_b(div_b), .div_c(div_c),
    .res0_valid(res0_valid), .res1_valid(res1_valid), .res_data(res_data),
    .inflight(inflight), .busy(busy)
  );

  // Divider stub: true quotients for the directed pairs, an arbitrary
  // operand mix otherwise (routing is what is under test).
  function automatic logic [31:0] fdiv_ref(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h40000000_3F800000: return 32'h40000000;
      64'h42000000_40000000: return 32'h41800000;
      64'h3FC00000_3E000000: return 32'h41400000;
      64'h447A0000_3F800000: return 32'h447A0000;
      64'h3DCCCCCD_42480000: return 32'h3B03126F;
      64'h41100000_3EA8F5C3: return 32'h41DA2E8B;
      default:               return (a ^ {b[15:0], b[31:16]}) + 32'h9E3779B9;
    endcase
  endfunction

  logic [31:0] dpipe [LAT];
  always @(posedge clk) begin
    dpipe[0] <= fdiv_ref(div_a, div_b);
    for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign div_c = dpipe[LAT-1];

  typedef struct {
    logic        v0;
    logic [31:0] a0, b0;
    logic        v1;
    logic [31:0] a1, b1;
    logic        chk_r, r0, r1;
    logic        use_q;
    logic [31:0] q;
  } vec_t;

  int checks = 0, failures = 0;
  int ecnt = 0, m_inf = 0, max_inf = 0, busy_lo = 0;
  logic        m_last;
  logic [31:0] m_da, m_db, m_res;
  logic        exp_v  [NE];
  logic        exp_id [NE];
  logic [31:0] exp_q  [NE];
  int          pulses [$];
  vec_t        tbl [10];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (edge %0d)", nm, got, exp, ecnt);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NE; i++) begin exp_v[i] = 1'b0; exp_id[i] = 1'b0; exp_q[i] = '0; end
    m_last = 1'b1; m_inf = 0; m_da = '0; m_db = '0; m_res = '0;
  endtask

  task automatic check_zero();
    chk("rst_div_a", div_a, 32'h0);
    chk("rst_div_b", div_b, 32'h0);
    chk("rst_res_data", res_data, 32'h0);
    chk("rst_res0_valid", res0_valid, 1'b0);
    chk("rst_res1_valid", res1_valid, 1'b0);
    chk("rst_inflight", inflight, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req0_ready", req0_ready, 1'b0);
    chk("rst_req1_ready", req1_ready, 1'b0);
  endtask

  task automatic check_outs();
    chk("res0_valid", res0_valid, exp_v[ecnt] && !exp_id[ecnt]);
    chk("res1_valid", res1_valid, exp_v[ecnt] && exp_id[ecnt]);
    chk("res_data", res_data, m_res);
    chk("div_a", div_a, m_da);
    chk("div_b", div_b, m_db);
    chk("inflight", inflight, m_inf);
    chk("busy", busy, m_inf != 0);
    if (res0_valid || res1_valid) pulses.push_back(ecnt);
    if (int'(inflight) > max_inf) max_inf = int'(inflight);
    if (!busy) busy_lo++;
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model
  // across the rising edge.
  task automatic cyc(input vec_t v);
    logic g0, g1;
    int   idx;
    @(negedge clk);
    req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0;
    req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1;
    #1;
    g0 = v.v0 && (!v.v1 || m_last);
    g1 = v.v1 && (!v.v0 || !m_last);
    chk("req0_ready", req0_ready, g0);
    chk("req1_ready", req1_ready, g1);
    if (v.chk_r) begin
      chk("tbl_req0_ready", req0_ready, v.r0);
      chk("tbl_req1_ready", req1_ready, v.r1);
    end
    check_outs();
    @(posedge clk);
    ecnt++;
    if (exp_v[ecnt]) m_res = exp_q[ecnt];
    m_inf = m_inf + ((g0 || g1) ? 1 : 0) - (exp_v[ecnt] ? 1 : 0);
    if (g0 || g1) begin
      m_last = g1;
      m_da   = g1 ? v.a1 : v.a0;
      m_db   = g1 ? v.b1 : v.b0;
      idx    = ecnt + LAT + 1;
      if (idx < NE) begin
        exp_v[idx]  = 1'b1;
        exp_id[idx] = g1;
        exp_q[idx]  = v.use_q ? v.q : fdiv_ref(m_da, m_db);
      end
    end
  endtask

  task automatic do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0;
    #3 rst = 1'b0;
    #1 check_zero();
    clear_model();
    repeat (2) begin @(posedge clk); ecnt++; end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); ecnt++;
  endtask

  function automatic vec_t idle_v();
    vec_t v;
    v = '{v0: 1'b0, a0: '0, b0: '0, v1: 1'b0, a1: '0, b1: '0,
          chk_r: 1'b0, r0: 1'b0, r1: 1'b0, use_q: 1'b0, q: '0};
    return v;
  endfunction

  function automatic vec_t mk(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                              input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                              input logic r0, input logic r1, input logic [31:0] q);
    vec_t v;
    v = '{v0: v0, a0: a0, b0: b0, v1: v1, a1: a1, b1: b1,
          chk_r: 1'b1, r0: r0, r1: r1, use_q: 1'b1, q: q};
    return v;
  endfunction

  function automatic vec_t rnd_v(input int pv, input logic force_one);
    vec_t v;
    v = idle_v();
    v.v0 = ($urandom_range(0, 99) < pv);
    v.v1 = ($urandom_range(0, 99) < pv);
    if (force_one && !v.v0 && !v.v1) v.v0 = 1'b1;
    v.a0 = $urandom; v.b0 = $urandom; v.a1 = $urandom; v.b1 = $urandom;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed vectors: single req0, req1 alone x3, then contention x6.
    tbl[0] = mk(1, 32'h40000000, 32'h3F800000, 0, 0, 0, 1, 0, 32'h40000000);
    tbl[1] = mk(0, 0, 0, 1, 32'h447A0000, 32'h3F800000, 0, 1, 32'h447A0000);
    tbl[2] = mk(0, 0, 0, 1, 32'h3DCCCCCD, 32'h42480000, 0, 1, 32'h3B03126F);
    tbl[3] = mk(0, 0, 0, 1, 32'h41100000, 32'h3EA8F5C3, 0, 1, 32'h41DA2E8B);
    for (int i = 4; i < 10; i++)
      tbl[i] = mk(1, 32'h42000000, 32'h40000000, 1, 32'h3FC00000, 32'h3E000000,
                  (i % 2) == 0, (i % 2) == 1, (i % 2) == 0 ? 32'h41800000 : 32'h41400000);

    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_zero();
    rst = 1'b1;
    @(posedge clk); ecnt++;

    for (int i = 0; i < 10; i++) cyc(tbl[i]);
    repeat (LAT + 3) cyc(idle_v());
    chk("drain_inflight", inflight, 32'h0);

    // Full-rate stream: inflight climbs to and holds at LAT+1.
    max_inf = 0;
    cyc(rnd_v(60, 1'b1));
    busy_lo = 0;
    repeat (LAT + 3) cyc(rnd_v(60, 1'b1));
    chk("stream_max_inflight", max_inf, LAT + 1);
    chk("stream_busy_low_cycles", busy_lo, 0);
    chk("stream_inflight_held", inflight, LAT + 1);
    repeat (LAT + 3) cyc(idle_v());
    chk("stream_drain_inflight", inflight, 32'h0);

    // Reset with four ops in flight: nothing may come back afterwards.
    repeat (4) cyc(rnd_v(70, 1'b1));
    do_reset();
    pulses.delete();
    repeat (2 * LAT) cyc(idle_v());
    chk("post_reset_pulses", pulses.size(), 0);

    // Idle gaps: two issues four edges apart give two pulses four apart.
    pulses.delete();
    begin
      vec_t v;
      v = idle_v(); v.v0 = 1'b1; v.a0 = 32'h12345678; v.b0 = 32'h3F800001;
      cyc(v);
      repeat (3) cyc(idle_v());
      v = idle_v(); v.v1 = 1'b1; v.a1 = 32'hC0A00000; v.b1 = 32'h40400000;
      cyc(v);
    end
    repeat (LAT + 6) cyc(idle_v());
    chk("gap_pulse_count", pulses.size(), 2);
    if (pulses.size() == 2) chk("gap_pulse_spacing", pulses[1] - pulses[0], 4);

    // Random traffic against the model.
    repeat (300) cyc(rnd_v(55, 1'b0));
    repeat (LAT + 3) cyc(idle_v());
    chk("final_inflight", inflight, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fdiv_rr_sched.md
Name: fdiv_rr_sched

Overview:
- Round-robin scheduler that shares one pipelined Newton-Raphson FP32 divider (NR_DIV: clk, rst, A, B, C) between two requesters.
- Accepts at most one operand pair per cycle and drives the divider's A/B from registers.
- Carries a valid/tag bit down a shift register matched to the divider latency.
- Returns each quotient to the requester that issued it, in issue order.

Parameters:
- DIV_LAT, 12, clock edges from a change on the divider's A/B inputs to the corresponding quotient on C; legal range 1..64.
- CW, 7, width of the in-flight counter; must satisfy 2^CW > DIV_LAT+1.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has an operand pair
- req0_a  in  32  requester 0 dividend, IEEE-754 single
- req0_b  in  32  requester 0 divisor, IEEE-754 single
- req0_ready  out  1  requester 0 pair accepted this cycle
- req1_valid  in  1  requester 1 has an operand pair
- req1_a  in  32  requester 1 dividend
- req1_b  in  32  requester 1 divisor
- req1_ready  out  1  requester 1 pair accepted this cycle
- div_a  out  32  to NR_DIV.A
- div_b  out  32  to NR_DIV.B
- div_c  in  32  from NR_DIV.C
- res0_valid  out  1  one-cycle pulse: res_data belongs to requester 0
- res1_valid  out  1  one-cycle pulse: res_data belongs to requester 1
- res_data  out  32  quotient
- inflight  out  CW  operations issued and not yet returned
- busy  out  1  inflight != 0

Behaviour:
- Reset (rst=0, asynchronous): clear all state.
  - div_a, div_b, res_data = 0.
  - res0_valid, res1_valid = 0; inflight = 0; busy = 0.
  - Tag pipe all invalid; round-robin pointer last = 1, so requester 0 wins first.
- Reset mid-operation discards all in-flight operations. No res*_valid may fire for them after reset release.
- Arbitration (combinational, same cycle):
  - Only req0_valid high: req0_ready=1.
  - Only req1_valid high: req1_ready=1.
  - Both high: grant the requester not equal to last.
  - Neither high: both ready=0.
  - req*_ready never asserts without its own req*_valid; the two readys are mutually exclusive.
- Issue (rising edge with a grant g):
  - div_a/div_b <= granted operands.
  - tag[0] <= {valid=1, id=g}; last <= g.
- No grant: div_a/div_b hold their value; tag[0] <= invalid.
- Tag pipe: DIV_LAT+1 stages (tag[0]..tag[DIV_LAT]), shifting every edge unconditionally. There is no stall; the divider has no enable.
- Return: when tag[DIV_LAT] is valid on an edge:
  - res_data <= div_c.
  - res{id}_valid <= 1 for exactly one cycle.
  - Otherwise both res*_valid <= 0 and res_data holds.
- Latency: a pair accepted at edge k gives res*_valid high during the cycle after edge k+DIV_LAT+1.
- Throughput: 1 per cycle. Results leave in issue order. Requesters must always accept results; there is no result backpressure.
- inflight:
  - +1 on issue, -1 on return, unchanged when both happen on the same edge.
  - Saturates at neither end. Its maximum by construction is DIV_LAT+1.
- Operand values are passed untouched. Zero, Inf and NaN handling belong to the divider.
- The same requester issuing back-to-back is legal when the other is idle.

Test Plan:
- Reset, then req0: a=0x40000000, b=0x3F800000 for one cycle. Required: req0_ready=1 that cycle; res0_valid pulses exactly once, DIV_LAT+1 edges later, with res_data=0x40000000; res1_valid stays 0; inflight returns to 0.
- req0 and req1 both valid continuously for 6 cycles. req0: a=0x42000000, b=0x40000000. req1: a=0x3FC00000, b=0x3E000000. Required: grants alternate 0,1,0,1,0,1; results alternate res0=0x41800000 and res1=0x41400000, one per cycle.
- req1 alone for 3 consecutive cycles. Operands: 0x447A0000/0x3F800000, then 0x3DCCCCCD/0x42480000, then 0x41100000/0x3EA8F5C3. Required: ready every cycle; res1 returns 0x447A0000, 0x3B03126F, 0x41DA2E8B in order on consecutive cycles.
- Issue on every cycle for DIV_LAT+4 cycles. Required: inflight reaches DIV_LAT+1 and holds there; busy=1 throughout; inflight falls to 0 after the stream stops.
- Assert rst=0 asynchronously with 4 ops in flight, for 2 cycles. Required: all outputs 0 immediately; no res*_valid within 2*DIV_LAT cycles after release.
- Idle gaps: issue, 3 idle cycles, issue. Required: div_a/div_b hold between issues; exactly two result pulses, spaced 4 cycles apart.
